// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - shared size encodings, FSM state type and byte-lane helpers
package core_bus_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte lanes touched by an access of the given size at the given byte offset.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] sel;
        case (size)
            SIZE_B:  sel = 4'b0001 << off;
            SIZE_H:  sel = off[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Naturally aligned accesses of a defined size are the only ones put on the bus.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// rtl/wb_lane_align.sv - byte-lane select, store replication and load extraction
module wb_lane_align
    import core_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted;

    // Store data is replicated across all lanes; load data is shifted down, truncated and extended.
    always_comb begin
        sel       = lane_sel(size, off);
        shifted   = rdata >> {off, 3'b000};
        wdata_rep = wdata;
        rdata_fmt = shifted;
        case (size)
            SIZE_B: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_wb_master.sv
// rtl/data_mem_wb_master.sv - core load/store request to Wishbone-classic data-memory master
module data_mem_wb_master
    import core_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              data_mem_cyc,
    output logic              data_mem_stb,
    output logic              data_mem_we,
    output logic [3:0]        data_mem_sel,
    output logic [ADDR_W-1:0] data_mem_addr,
    output logic [31:0]       data_mem_data_out,
    input  logic [31:0]       data_mem_data_in,
    input  logic              data_mem_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              lat_we;
    logic              lat_signed;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic              legal;
    logic              timed_out;
    logic [1:0]        la_size;
    logic [1:0]        la_off;
    logic              la_signed;
    logic [3:0]        la_sel;
    logic [31:0]       la_wdata;
    logic [31:0]       la_rdata;

    assign req_ready = (state == ST_IDLE);
    assign legal     = req_legal(req_size, req_addr[1:0]);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // The aligner sees the live request while idle (store path) and the latched one during the bus cycle (load path).
    assign la_size   = req_ready ? req_size   : lat_size;
    assign la_off    = req_ready ? req_addr[1:0] : lat_off;
    assign la_signed = req_ready ? req_signed : lat_signed;

    wb_lane_align u_align (
        .size      (la_size),
        .off       (la_off),
        .sgn       (la_signed),
        .wdata     (req_wdata),
        .rdata     (data_mem_data_in),
        .sel       (la_sel),
        .wdata_rep (la_wdata),
        .rdata_fmt (la_rdata)
    );

    // State register.
    always_ff @(posedge clk_core) begin
        if (rst_core) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: illegal requests skip the bus; ack takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = legal ? ST_BUS : ST_RESP;
            ST_BUS:  if (data_mem_ack || timed_out) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered bus outputs, request latch, timeout counter and one-cycle response.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            data_mem_cyc      <= 1'b0;
            data_mem_stb      <= 1'b0;
            data_mem_we       <= 1'b0;
            data_mem_sel      <= 4'b0000;
            data_mem_addr     <= '0;
            data_mem_data_out <= '0;
            resp_valid        <= 1'b0;
            resp_err          <= 1'b0;
            resp_rdata        <= '0;
            tmo_cnt           <= '0;
            lat_we            <= 1'b0;
            lat_signed        <= 1'b0;
            lat_size          <= SIZE_B;
            lat_off           <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            data_mem_cyc      <= 1'b1;
                            data_mem_stb      <= 1'b1;
                            data_mem_we       <= req_we;
                            data_mem_sel      <= la_sel;
                            data_mem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                            data_mem_data_out <= la_wdata;
                            lat_we            <= req_we;
                            lat_signed        <= req_signed;
                            lat_size          <= req_size;
                            lat_off           <= req_addr[1:0];
                            tmo_cnt           <= '0;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (data_mem_ack || timed_out) begin
                        data_mem_cyc      <= 1'b0;
                        data_mem_stb      <= 1'b0;
                        data_mem_we       <= 1'b0;
                        data_mem_sel      <= 4'b0000;
                        data_mem_addr     <= '0;
                        data_mem_data_out <= '0;
                        resp_valid        <= 1'b1;
                        resp_err          <= ~data_mem_ack;
                        resp_rdata        <= (data_mem_ack && !lat_we) ? la_rdata : 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_wb_master.sv
// tb/tb_data_mem_wb_master.sv - scoreboard bench for data_mem_wb_master
module tb_data_mem_wb_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] addr, dout;
    logic [31:0] din = 32'd0;
    logic        ack = 1'b0;
    logic        stray_ack = 1'b0;

    data_mem_wb_master #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk_core(clk), .rst_core(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .data_mem_cyc(cyc), .data_mem_stb(stb),
        .data_mem_we(we), .data_mem_sel(sel), .data_mem_addr(addr),
        .data_mem_data_out(dout), .data_mem_data_in(din), .data_mem_ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dout;
        logic [31:0] din;
        int          ws;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on byte counts and offsets.
    function automatic bit m_legal(input int size, input logic [31:0] a);
        if (size == 3) return 1'b0;
        return (a % (1 << size)) == 0;
    endfunction

    function automatic logic [31:0] m_rdata(input int size, input bit sgn, input logic [31:0] a, input logic [31:0] d);
        int     nb = 1 << size;
        longint v  = longint'(d) >> (8 * (a % 4));
        longint mask;
        if (nb == 4) return d;
        mask = (longint'(1) << (8 * nb)) - 1;
        v = v & mask;
        if (sgn && (((v >> (8 * nb - 1)) & 1) == 1)) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_dout(input int size, input logic [31:0] w);
        logic [31:0] r;
        int nb = 1 << size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
        return r;
    endfunction

    // Issue one request; push bus and response expectations before the accepting edge.
    task automatic do_req(input bit w, input int size, input bit sgn, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] d, input int ws, input bit abort);
        int    guard = 0;
        int    acc;
        bit    lg = m_legal(size, a);
        int    eff = (ws < T) ? ws : T;
        resp_t r;
        bus_t  b;
        req_we = w; req_size = size[1:0]; req_signed = sgn; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("req_ready_wait", 32'(guard < 50), 32'd1);
        acc = cyc_cnt + 1;
        if (lg) begin
            b.we = w; b.sel = 4'(((1 << (1 << size)) - 1) << (a % 4));
            b.addr = a & ~32'd3; b.dout = m_dout(size, wd); b.din = d; b.ws = ws;
            bus_q.push_back(b);
        end
        if (!abort) begin
            r.err   = !lg || (ws > T);
            r.rdata = (r.err || w) ? 32'd0 : m_rdata(size, sgn, a, d);
            r.cyc   = lg ? acc + 1 + eff : acc;
            resp_q.push_back(r);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_wait", 32'(guard < 50), 32'd1);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    // Slave model: checks the bus fields every cycle, acks after the chosen wait states.
    bus_t cur;
    bit   active = 1'b0;
    int   waited = 0;
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            ack = 1'b0;
        end else if (cyc) begin
            if (!active) begin
                chk("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) cur = bus_q.pop_front();
                else cur = '{we: 1'b0, sel: 4'd0, addr: 32'd0, dout: 32'd0, din: 32'd0, ws: 0};
                active = 1'b1;
                waited = 0;
            end
            chk("bus_stb", 32'(stb), 32'd1);
            chk("bus_we", 32'(we), 32'(cur.we));
            chk("bus_sel", 32'(sel), 32'(cur.sel));
            chk("bus_addr", addr, cur.addr);
            if (cur.we) chk("bus_data_out", dout, cur.dout);
            if (waited == cur.ws) begin
                ack = 1'b1;
                din = cur.din;
            end else begin
                ack = 1'b0;
                din = $urandom;
            end
            waited++;
        end else begin
            if (active) begin
                chk("bus_len", waited, ((cur.ws < T) ? cur.ws : T) + 1);
                active = 1'b0;
            end
            ack = stray_ack;
            din = $urandom;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_cyc_stb_we", {29'd0, cyc, stb, we}, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_data_out", dout, 32'd0);
        chk("rst_resp", {resp_valid, resp_err, 30'd0} | resp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        do_req(1'b0, 0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 3, 1'b0);
        do_req(1'b0, 1, 1'b0, 32'h202, 32'h0, 32'hA5A51234, 1, 1'b0);
        do_req(1'b0, 2, 1'b0, 32'h101, 32'h0, 32'h12345678, 0, 1'b0);
        do_req(1'b0, 2, 1'b0, 32'h400, 32'h0, 32'h11111111, 99, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1 stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray_ack = 1'b0;
        do_req(1'b0, 1, 1'b1, 32'h506, 32'h0, 32'h8001CAFE, T, 1'b0);
        do_req(1'b0, 0, 1'b0, 32'h601, 32'h0, 32'h0000F200, 0, 1'b0);
        do_req(1'b0, 3, 1'b0, 32'h700, 32'h0, 32'h0, 0, 1'b0);

        wait_idle();
        do_req(1'b1, 1, 1'b0, 32'h302, 32'h0000BEEF, 32'h0, 99, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_addr", addr, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 stray_ack = 1'b0;

        for (int n = 0; n < 80; n++) begin
            int r  = $urandom_range(0, 9);
            int sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            int rw = $urandom_range(0, 9);
            int ws = (rw == 9) ? 99 : (rw % 5);
            logic [31:0] a = 32'($urandom_range(0, 4095));
            if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, ws, 1'b0);
        end

        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
